// File: rtl/exe_stage_if.sv
// exe_stage_if: ID/EXE operands and controls in, EXE/MEM results out, WB forwarding taps.
// With EXE_FWD_EN defined the bundle also carries the source register numbers rs1_in/rs2_in.
`ifndef DSIZE
`define DSIZE 16
`endif
`ifndef ASIZE
`define ASIZE 5
`endif
`ifndef ISIZE
`define ISIZE 16
`endif

interface exe_stage_if #(
    parameter int unsigned DSIZE = `DSIZE,
    parameter int unsigned ASIZE = `ASIZE,
    parameter int unsigned ISIZE = `ISIZE
);
    logic [DSIZE-1:0] rdata1_in;
    logic [DSIZE-1:0] rdata2_in;
    logic [DSIZE-1:0] imm_in;
    logic [2:0]       opcode_in;
    logic             alusrc_in;
    logic [ASIZE-1:0] waddr_in;
    logic             wen_in;
    logic             memWrite_in;
    logic             memRead_in;
    logic             memToReg_in;
    logic             branch_in;
    logic [ISIZE-1:0] PC_in;
`ifdef EXE_FWD_EN
    logic [ASIZE-1:0] rs1_in;
    logic [ASIZE-1:0] rs2_in;
`endif
    logic [ASIZE-1:0] wb_waddr_in;
    logic             wb_wen_in;
    logic [DSIZE-1:0] wb_wdata_in;

    logic             stall_out;
    logic [DSIZE-1:0] alu_out;
    logic [DSIZE-1:0] wdata_out;
    logic [ASIZE-1:0] waddr_out;
    logic             wen_out;
    logic             memWrite_out;
    logic             memRead_out;
    logic             memToReg_out;
    logic             br_taken_out;
    logic [ISIZE-1:0] br_target_out;

    modport master (
`ifdef EXE_FWD_EN
        output rs1_in, rs2_in,
`endif
        output rdata1_in, rdata2_in, imm_in, opcode_in, alusrc_in, waddr_in, wen_in,
        output memWrite_in, memRead_in, memToReg_in, branch_in, PC_in,
        output wb_waddr_in, wb_wen_in, wb_wdata_in,
        input  stall_out, alu_out, wdata_out, waddr_out, wen_out,
        input  memWrite_out, memRead_out, memToReg_out, br_taken_out, br_target_out
    );

    modport slave (
`ifdef EXE_FWD_EN
        input  rs1_in, rs2_in,
`endif
        input  rdata1_in, rdata2_in, imm_in, opcode_in, alusrc_in, waddr_in, wen_in,
        input  memWrite_in, memRead_in, memToReg_in, branch_in, PC_in,
        input  wb_waddr_in, wb_wen_in, wb_wdata_in,
        output stall_out, alu_out, wdata_out, waddr_out, wen_out,
        output memWrite_out, memRead_out, memToReg_out, br_taken_out, br_target_out
    );
endinterface

// File: rtl/exe_stage.sv
// exe_stage: execute stage (single-cycle ALU, iterative shift-add MUL, BEQ resolve) plus EXE/MEM register.
// Define EXE_FWD_EN to add EXE/MEM and WB forwarding on operand A and the rdata2 path.
`ifndef DSIZE
`define DSIZE 16
`endif
`ifndef ASIZE
`define ASIZE 5
`endif
`ifndef ISIZE
`define ISIZE 16
`endif

module exe_stage #(
    parameter int unsigned DSIZE = `DSIZE,
    parameter int unsigned ASIZE = `ASIZE,
    parameter int unsigned ISIZE = `ISIZE
) (
    input  logic       clk,
    input  logic       rst,
    exe_stage_if.slave bus
);
    localparam int unsigned    CW       = (DSIZE > 1) ? $clog2(DSIZE) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DSIZE - 1);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLT = 3'd5;
    localparam logic [2:0] OP_SLL = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DSIZE-1:0] acc_q, acc_d;
    logic [DSIZE-1:0] mcand_q, mcand_d;
    logic [DSIZE-1:0] mplier_q, mplier_d;
    logic [ASIZE-1:0] mul_waddr_q, mul_waddr_d;
    logic             mul_wen_q, mul_wen_d;
    logic             mul_memwrite_q, mul_memwrite_d;
    logic             mul_memread_q, mul_memread_d;
    logic             mul_memtoreg_q, mul_memtoreg_d;

    logic [DSIZE-1:0] alu_q, alu_d;
    logic [DSIZE-1:0] wdata_q, wdata_d;
    logic [ASIZE-1:0] waddr_q, waddr_d;
    logic             wen_q, wen_d;
    logic             memwrite_q, memwrite_d;
    logic             memread_q, memread_d;
    logic             memtoreg_q, memtoreg_d;
    logic             br_taken_q, br_taken_d;
    logic [ISIZE-1:0] br_target_q, br_target_d;

    logic             stall_c;
    logic [DSIZE-1:0] a_c, b_reg_c, b_c, alu_c, step_c;

    // Operand selection: register-file values, optionally overridden by in-flight results
`ifdef EXE_FWD_EN
    always_comb begin
        a_c = bus.rdata1_in;
        if (wen_q && (waddr_q == bus.rs1_in) && (waddr_q != '0))
            a_c = alu_q;
        else if (bus.wb_wen_in && (bus.wb_waddr_in == bus.rs1_in) && (bus.wb_waddr_in != '0))
            a_c = bus.wb_wdata_in;

        b_reg_c = bus.rdata2_in;
        if (wen_q && (waddr_q == bus.rs2_in) && (waddr_q != '0))
            b_reg_c = alu_q;
        else if (bus.wb_wen_in && (bus.wb_waddr_in == bus.rs2_in) && (bus.wb_waddr_in != '0))
            b_reg_c = bus.wb_wdata_in;
    end
`else
    logic unused_wb;
    assign unused_wb = ^{bus.wb_waddr_in, bus.wb_wen_in, bus.wb_wdata_in};
    assign a_c       = bus.rdata1_in;
    assign b_reg_c   = bus.rdata2_in;
`endif

    assign b_c    = bus.alusrc_in ? bus.imm_in : b_reg_c;
    assign step_c = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        alu_c = '0;
        case (bus.opcode_in)
            OP_ADD:  alu_c = a_c + b_c;
            OP_SUB:  alu_c = a_c - b_c;
            OP_AND:  alu_c = a_c & b_c;
            OP_OR:   alu_c = a_c | b_c;
            OP_XOR:  alu_c = a_c ^ b_c;
            OP_SLT:  alu_c = DSIZE'($signed(a_c) < $signed(b_c));
            OP_SLL:  alu_c = a_c << b_c[3:0];
            default: alu_c = '0;
        endcase
    end

    // Next state: single-cycle ops load EXE/MEM directly; MUL bubbles until its last step
    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        acc_d          = acc_q;
        mcand_d        = mcand_q;
        mplier_d       = mplier_q;
        mul_waddr_d    = mul_waddr_q;
        mul_wen_d      = mul_wen_q;
        mul_memwrite_d = mul_memwrite_q;
        mul_memread_d  = mul_memread_q;
        mul_memtoreg_d = mul_memtoreg_q;
        alu_d          = alu_q;
        wdata_d        = wdata_q;
        waddr_d        = waddr_q;
        wen_d          = wen_q;
        memwrite_d     = memwrite_q;
        memread_d      = memread_q;
        memtoreg_d     = memtoreg_q;
        br_taken_d     = br_taken_q;
        br_target_d    = br_target_q;
        stall_c        = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.opcode_in == OP_MUL) begin
                    stall_c        = 1'b1;
                    acc_d          = '0;
                    mcand_d        = a_c;
                    mplier_d       = b_c;
                    count_d        = '0;
                    mul_waddr_d    = bus.waddr_in;
                    mul_wen_d      = bus.wen_in;
                    mul_memwrite_d = bus.memWrite_in;
                    mul_memread_d  = bus.memRead_in;
                    mul_memtoreg_d = bus.memToReg_in;
                    wen_d          = 1'b0;
                    memwrite_d     = 1'b0;
                    memread_d      = 1'b0;
                    br_taken_d     = 1'b0;
                    state_d        = BUSY;
                end else begin
                    alu_d       = alu_c;
                    wdata_d     = b_reg_c;
                    waddr_d     = bus.waddr_in;
                    wen_d       = bus.wen_in;
                    memwrite_d  = bus.memWrite_in;
                    memread_d   = bus.memRead_in;
                    memtoreg_d  = bus.memToReg_in;
                    br_taken_d  = bus.branch_in && (a_c == b_reg_c);
                    br_target_d = bus.PC_in + bus.imm_in[ISIZE-1:0];
                end
            end
            BUSY: begin
                acc_d      = step_c;
                mcand_d    = mcand_q << 1;
                mplier_d   = mplier_q >> 1;
                count_d    = count_q + CW'(1);
                wen_d      = 1'b0;
                memwrite_d = 1'b0;
                memread_d  = 1'b0;
                br_taken_d = 1'b0;
                if (count_q == CNT_LAST) begin
                    alu_d      = step_c;
                    waddr_d    = mul_waddr_q;
                    wen_d      = mul_wen_q;
                    memwrite_d = mul_memwrite_q;
                    memread_d  = mul_memread_q;
                    memtoreg_d = mul_memtoreg_q;
                    state_d    = IDLE;
                end else begin
                    stall_c = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            count_q        <= '0;
            acc_q          <= '0;
            mcand_q        <= '0;
            mplier_q       <= '0;
            mul_waddr_q    <= '0;
            mul_wen_q      <= 1'b0;
            mul_memwrite_q <= 1'b0;
            mul_memread_q  <= 1'b0;
            mul_memtoreg_q <= 1'b0;
            alu_q          <= '0;
            wdata_q        <= '0;
            waddr_q        <= '0;
            wen_q          <= 1'b0;
            memwrite_q     <= 1'b0;
            memread_q      <= 1'b0;
            memtoreg_q     <= 1'b0;
            br_taken_q     <= 1'b0;
            br_target_q    <= '0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            acc_q          <= acc_d;
            mcand_q        <= mcand_d;
            mplier_q       <= mplier_d;
            mul_waddr_q    <= mul_waddr_d;
            mul_wen_q      <= mul_wen_d;
            mul_memwrite_q <= mul_memwrite_d;
            mul_memread_q  <= mul_memread_d;
            mul_memtoreg_q <= mul_memtoreg_d;
            alu_q          <= alu_d;
            wdata_q        <= wdata_d;
            waddr_q        <= waddr_d;
            wen_q          <= wen_d;
            memwrite_q     <= memwrite_d;
            memread_q      <= memread_d;
            memtoreg_q     <= memtoreg_d;
            br_taken_q     <= br_taken_d;
            br_target_q    <= br_target_d;
        end
    end

    // Stall is held low while reset is asserted so upstream never freezes on reset
    assign bus.stall_out     = stall_c & ~rst;
    assign bus.alu_out       = alu_q;
    assign bus.wdata_out     = wdata_q;
    assign bus.waddr_out     = waddr_q;
    assign bus.wen_out       = wen_q;
    assign bus.memWrite_out  = memwrite_q;
    assign bus.memRead_out   = memread_q;
    assign bus.memToReg_out  = memtoreg_q;
    assign bus.br_taken_out  = br_taken_q;
    assign bus.br_target_out = br_target_q;
endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: scoreboard bench for exe_stage (ALU ops, MUL timing, reset abort, BEQ, forwarding).
module tb_exe_stage;
    localparam int unsigned DSIZE = 16;
    localparam int unsigned ASIZE = 5;
    localparam int unsigned ISIZE = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    exe_stage_if #(.DSIZE(DSIZE), .ASIZE(ASIZE), .ISIZE(ISIZE)) bus ();
    exe_stage #(.DSIZE(DSIZE), .ASIZE(ASIZE), .ISIZE(ISIZE)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [DSIZE-1:0] a, b, imm;
        logic [2:0]       op;
        logic             alusrc;
        logic [ASIZE-1:0] waddr;
        logic             wen, mw, mr, m2r, br;
        logic [ISIZE-1:0] pc;
    } in_t;

    typedef struct packed {
        logic [DSIZE-1:0] alu, wdata;
        logic [ASIZE-1:0] waddr;
        logic             wen, mw, mr, m2r, bt;
        logic [ISIZE-1:0] btgt;
        logic             full;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic in_t mk(input logic [2:0] op, input logic [DSIZE-1:0] a, input logic [DSIZE-1:0] b,
                               input logic [DSIZE-1:0] imm, input logic alusrc);
        in_t x;
        x        = '0;
        x.op     = op;
        x.a      = a;
        x.b      = b;
        x.imm    = imm;
        x.alusrc = alusrc;
        x.waddr  = ASIZE'(op) + ASIZE'(1);
        x.wen    = 1'b1;
        x.pc     = 16'h0100;
        return x;
    endfunction

    // Reference model of what EXE/MEM should hold for one instruction
    function automatic exp_t model(input in_t x);
        exp_t e;
        logic [DSIZE-1:0] bb;
        bb = x.alusrc ? x.imm : x.b;
        e  = '0;
        case (x.op)
            3'd0:    e.alu = x.a + bb;
            3'd1:    e.alu = x.a - bb;
            3'd2:    e.alu = x.a & bb;
            3'd3:    e.alu = x.a | bb;
            3'd4:    e.alu = x.a ^ bb;
            3'd5:    e.alu = ($signed(x.a) < $signed(bb)) ? 16'd1 : 16'd0;
            3'd6:    e.alu = x.a << bb[3:0];
            default: e.alu = x.a * bb;
        endcase
        e.wdata = x.b;
        e.waddr = x.waddr;
        e.wen   = x.wen;
        e.mw    = x.mw;
        e.mr    = x.mr;
        e.m2r   = x.m2r;
        e.bt    = (x.op != 3'd7) && x.br && (x.a == x.b);
        e.btgt  = x.pc + x.imm;
        e.full  = (x.op != 3'd7);
        return e;
    endfunction

    function automatic exp_t sample();
        exp_t v;
        v.alu   = bus.alu_out;
        v.wdata = bus.wdata_out;
        v.waddr = bus.waddr_out;
        v.wen   = bus.wen_out;
        v.mw    = bus.memWrite_out;
        v.mr    = bus.memRead_out;
        v.m2r   = bus.memToReg_out;
        v.bt    = bus.br_taken_out;
        v.btgt  = bus.br_target_out;
        v.full  = 1'b0;
        return v;
    endfunction

    // MUL leaves store data and branch target as don't-care
    function automatic exp_t masked(input exp_t v, input logic full);
        exp_t r;
        r      = v;
        r.full = full;
        if (!full) begin
            r.wdata = '0;
            r.btgt  = '0;
        end
        return r;
    endfunction

    task automatic drive(input in_t x);
        bus.rdata1_in   = x.a;
        bus.rdata2_in   = x.b;
        bus.imm_in      = x.imm;
        bus.opcode_in   = x.op;
        bus.alusrc_in   = x.alusrc;
        bus.waddr_in    = x.waddr;
        bus.wen_in      = x.wen;
        bus.memWrite_in = x.mw;
        bus.memRead_in  = x.mr;
        bus.memToReg_in = x.m2r;
        bus.branch_in   = x.br;
        bus.PC_in       = x.pc;
    endtask

    task automatic issue(input in_t x);
        @(negedge clk);
        drive(x);
        sb.push_back(model(x));
    endtask

    task automatic test_reset();
        in_t x;
        exp_t e, act;
        x     = mk(3'd0, 16'h1111, 16'h1111, 16'h0022, 1'b0);
        x.mw  = 1'b1; x.mr = 1'b1; x.m2r = 1'b1; x.br = 1'b1;
        rst   = 1'b1;
        drive(x);
        repeat (2) @(posedge clk);
        #1;
        act = sample();
        checks++;
        if (act !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", act);
        end
        checks++;
        if (bus.stall_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_stall got=%b exp=0", bus.stall_out);
        end
        @(negedge clk);
        rst = 1'b0;
        sb.push_back(model(x));
        @(posedge clk);
        #1;
        e   = sb.pop_front();
        act = sample();
        checks++;
        if (masked(act, e.full) !== masked(e, e.full)) begin
            failures++;
            $display("FAIL reset_release got=%h exp=%h", masked(act, e.full), masked(e, e.full));
        end
    endtask

    task automatic test_alu();
        in_t              tv[10];
        logic [DSIZE-1:0] ev[10];
        exp_t             e, act;
        tv[0] = mk(3'd0, 16'd5,    16'd7,    16'd0,    1'b0); ev[0] = 16'd12;
        tv[1] = mk(3'd1, 16'd3,    16'd5,    16'd0,    1'b0); ev[1] = 16'hFFFE;
        tv[2] = mk(3'd5, 16'hFFFE, 16'd1,    16'd0,    1'b0); ev[2] = 16'd1;
        tv[3] = mk(3'd5, 16'd1,    16'hFFFE, 16'd0,    1'b0); ev[3] = 16'd0;
        tv[4] = mk(3'd2, 16'hF0F0, 16'hFF00, 16'd0,    1'b0); ev[4] = 16'hF000;
        tv[5] = mk(3'd3, 16'hF0F0, 16'h0F00, 16'd0,    1'b0); ev[5] = 16'hFFF0;
        tv[6] = mk(3'd4, 16'hFFFF, 16'h00FF, 16'd0,    1'b0); ev[6] = 16'hFF00;
        tv[7] = mk(3'd6, 16'h0003, 16'h0012, 16'd0,    1'b0); ev[7] = 16'h000C;
        tv[8] = mk(3'd0, 16'h0010, 16'h0099, 16'hFFFF, 1'b1); ev[8] = 16'h000F;
        tv[9] = mk(3'd0, 16'hFFFF, 16'h0001, 16'd0,    1'b0); ev[9] = 16'h0000;
        tv[4].mr = 1'b1; tv[4].m2r = 1'b1;
        tv[5].mw = 1'b1; tv[5].wen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            issue(tv[i]);
            #1;
            checks++;
            if (bus.stall_out !== 1'b0) begin
                failures++;
                $display("FAIL alu_stall[%0d] got=%b exp=0", i, bus.stall_out);
            end
            @(posedge clk);
            #1;
            e   = sb.pop_front();
            act = sample();
            checks++;
            if (masked(act, e.full) !== masked(e, e.full)) begin
                failures++;
                $display("FAIL alu_op[%0d] got=%h exp=%h", i, masked(act, e.full), masked(e, e.full));
            end
            checks++;
            if (bus.alu_out !== ev[i]) begin
                failures++;
                $display("FAIL alu_value[%0d] got=%h exp=%h", i, bus.alu_out, ev[i]);
            end
        end
    endtask

    task automatic test_mul(input in_t x, input logic [DSIZE-1:0] ev);
        exp_t e, act;
        logic s;
        int   stall_n, bubbles, bubble_bad;
        bit   done;
        stall_n = 0; bubbles = 0; bubble_bad = 0; done = 1'b0;
        issue(x);
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            s = bus.stall_out;
            if (s) stall_n++;
            @(posedge clk);
            #1;
            if (s) begin
                bubbles++;
                if (bus.wen_out !== 1'b0 || bus.memWrite_out !== 1'b0 || bus.memRead_out !== 1'b0 ||
                    bus.br_taken_out !== 1'b0)
                    bubble_bad++;
            end else begin
                done = 1'b1;
                e    = sb.pop_front();
                act  = sample();
                checks++;
                if (masked(act, e.full) !== masked(e, e.full)) begin
                    failures++;
                    $display("FAIL mul_result got=%h exp=%h", masked(act, e.full), masked(e, e.full));
                end
                checks++;
                if (bus.alu_out !== ev) begin
                    failures++;
                    $display("FAIL mul_value got=%h exp=%h", bus.alu_out, ev);
                end
            end
            if (!done) @(negedge clk);
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL mul_timeout stall never dropped within 40 cycles");
            void'(sb.pop_front());
        end
        checks++;
        if (stall_n != DSIZE) begin
            failures++;
            $display("FAIL mul_stall_cycles got=%0d exp=%0d", stall_n, DSIZE);
        end
        checks++;
        if (bubble_bad != 0 || bubbles != DSIZE) begin
            failures++;
            $display("FAIL mul_bubbles got=%0d bad=%0d exp=%0d bad=0", bubbles, bubble_bad, DSIZE);
        end
        @(negedge clk);
        drive(mk(3'd0, 16'd0, 16'd0, 16'd0, 1'b0));
    endtask

    task automatic test_mul_reset();
        in_t nop;
        nop     = '0;
        @(negedge clk);
        drive(mk(3'd7, 16'd1234, 16'd77, 16'd0, 1'b0));
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (bus.stall_out !== 1'b1) begin
            failures++;
            $display("FAIL mulrst_busy_stall got=%b exp=1", bus.stall_out);
        end
        @(negedge clk);
        rst = 1'b1;
        drive(nop);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.stall_out !== 1'b0) begin
            failures++;
            $display("FAIL mulrst_stall got=%b exp=0", bus.stall_out);
        end
        checks++;
        if (sample() !== '0) begin
            failures++;
            $display("FAIL mulrst_outputs got=%h exp=0", sample());
        end
    endtask

    task automatic test_branch();
        in_t  x;
        exp_t e, act;
        for (int i = 0; i < 2; i++) begin
            x    = mk(3'd1, 16'd9, (i == 0) ? 16'd9 : 16'd8, 16'd4, 1'b0);
            x.br = 1'b1;
            x.pc = 16'h0020;
            x.wen = 1'b0;
            issue(x);
            @(posedge clk);
            #1;
            e   = sb.pop_front();
            act = sample();
            checks++;
            if (masked(act, e.full) !== masked(e, e.full)) begin
                failures++;
                $display("FAIL branch[%0d] got=%h exp=%h", i, masked(act, e.full), masked(e, e.full));
            end
            checks++;
            if (bus.br_taken_out !== (i == 0) || bus.br_target_out !== 16'h0024) begin
                failures++;
                $display("FAIL branch_flags[%0d] got=%b/%h exp=%b/0024", i, bus.br_taken_out,
                         bus.br_target_out, (i == 0));
            end
        end
    endtask

    task automatic test_back_to_back();
        in_t  x;
        exp_t e, act;
        for (int i = 0; i < 24; i++) begin
            x       = mk(3'($urandom_range(0, 6)), 16'($urandom), 16'($urandom), 16'($urandom),
                         1'($urandom_range(0, 1)));
            x.waddr = 5'($urandom);
            x.wen   = 1'($urandom);
            x.mw    = 1'($urandom);
            x.mr    = 1'($urandom);
            x.m2r   = 1'($urandom);
            x.br    = 1'($urandom);
            x.pc    = 16'($urandom);
            if (i % 4 == 0) x.b = x.a;
            issue(x);
            @(posedge clk);
            #1;
            e   = sb.pop_front();
            act = sample();
            checks++;
            if (masked(act, e.full) !== masked(e, e.full)) begin
                failures++;
                $display("FAIL b2b[%0d] got=%h exp=%h", i, masked(act, e.full), masked(e, e.full));
            end
        end
    endtask

`ifdef EXE_FWD_EN
    task automatic test_fwd();
        in_t              x[5];
        logic [ASIZE-1:0] rs1[5], rs2[5], wba[5];
        logic             wbe[5];
        logic [DSIZE-1:0] wbd[5], ev[5];
        x[0] = mk(3'd0, 16'd5, 16'd7, 16'd0, 1'b0); x[0].waddr = 5'd3;
        rs1[0] = 5'd1; rs2[0] = 5'd2; wbe[0] = 1'b0; wba[0] = 5'd0; wbd[0] = 16'd0;   ev[0] = 16'd12;
        x[1] = mk(3'd0, 16'd0, 16'd1, 16'd0, 1'b0); x[1].waddr = 5'd5;
        rs1[1] = 5'd3; rs2[1] = 5'd4; wbe[1] = 1'b0; wba[1] = 5'd0; wbd[1] = 16'd0;   ev[1] = 16'd13;
        x[2] = mk(3'd0, 16'd4, 16'd1, 16'd0, 1'b0); x[2].waddr = 5'd2; x[2].wen = 1'b0;
        rs1[2] = 5'd0; rs2[2] = 5'd0; wbe[2] = 1'b1; wba[2] = 5'd0; wbd[2] = 16'd99;  ev[2] = 16'd5;
        x[3] = mk(3'd0, 16'd0, 16'd1, 16'd0, 1'b0); x[3].waddr = 5'd6;
        rs1[3] = 5'd6; rs2[3] = 5'd7; wbe[3] = 1'b1; wba[3] = 5'd6; wbd[3] = 16'd100; ev[3] = 16'd101;
        x[4] = mk(3'd0, 16'd0, 16'd1, 16'd0, 1'b0); x[4].waddr = 5'd8;
        rs1[4] = 5'd6; rs2[4] = 5'd7; wbe[4] = 1'b1; wba[4] = 5'd6; wbd[4] = 16'd200; ev[4] = 16'd102;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(x[i]);
            bus.rs1_in      = rs1[i];
            bus.rs2_in      = rs2[i];
            bus.wb_wen_in   = wbe[i];
            bus.wb_waddr_in = wba[i];
            bus.wb_wdata_in = wbd[i];
            @(posedge clk);
            #1;
            checks++;
            if (bus.alu_out !== ev[i]) begin
                failures++;
                $display("FAIL fwd[%0d] got=%0d exp=%0d", i, bus.alu_out, ev[i]);
            end
        end
        @(negedge clk);
        bus.wb_wen_in = 1'b0;
        bus.rs1_in    = '0;
        bus.rs2_in    = '0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wb_wen_in   = 1'b0;
        bus.wb_waddr_in = '0;
        bus.wb_wdata_in = '0;
`ifdef EXE_FWD_EN
        bus.rs1_in      = '0;
        bus.rs2_in      = '0;
`endif
        drive('0);
        test_reset();
        test_alu();
        test_mul(mk(3'd7, 16'd300, 16'd250, 16'd0, 1'b0), 16'd9464);
        test_mul_reset();
        test_mul(mk(3'd7, 16'hFFFF, 16'd3, 16'd0, 1'b0), 16'hFFFD);
        test_mul(mk(3'd7, 16'h1234, 16'hBEEF, 16'h0010, 1'b1), 16'h2340);
        test_branch();
        test_back_to_back();
`ifdef EXE_FWD_EN
        test_fwd();
`endif
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
